serial_subtractor: RTL and testbench

//  Bit-serial N-bit unsigned/two's-complement subtractor: Diff = A - B, computed
//  LSB-first, one bit per clock, through a single full-adder cell (A + ~B + 1)

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle for serial_subtractor
// Ovf is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             Ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
  modport master (output start, A, B, input busy, done, Diff, Borrow, Ovf);
  modport slave  (input start, A, B, output busy, done, Diff, Borrow, Ovf);
`else
  modport master (output start, A, B, input busy, done, Diff, Borrow);
  modport slave  (input start, A, B, output busy, done, Diff, Borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first A - B through one full-adder cell (A + ~B + 1)
// SERIAL_SUB_OVF_EN adds the registered signed-overflow output Ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave sub
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             nb;
  logic             s;
  logic             c_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  always_comb begin
    nb     = ~sh_b[0];
    s      = sh_a[0] ^ nb ^ carry;
    c_next = (sh_a[0] & nb) | (carry & (sh_a[0] ^ nb));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      res        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      sub.busy   <= 1'b0;
      sub.done   <= 1'b0;
      sub.Diff   <= '0;
      sub.Borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      sub.Ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sub.done <= 1'b0;
          sub.busy <= sub.start;
          if (sub.start) begin
            sh_a  <= sub.A;
            sh_b  <= sub.B;
            carry <= 1'b1;
            cnt   <= '0;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            // operand MSBs are shifted out before DONE, so keep them for Ovf
            a_msb <= sub.A[WIDTH-1];
            b_msb <= sub.B[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          carry <= c_next;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          res   <= {s, res[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          sub.Diff   <= res;
          sub.Borrow <= ~carry;
          sub.done   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          sub.Ovf    <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
`endif
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH 8 and 4
// Ovf is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .sub(if8));
  serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .sub(if4));

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } exp_t;

  exp_t       q8[$];
  exp_t       q4[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_diff8;
  int         lat;

  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int   ai, bi, d;
    ai = int'(a);
    bi = int'(b);
    r.diff   = 8'((ai - bi) & ((1 << w) - 1));
    r.borrow = (ai < bi);
    if (a[w-1]) ai = ai - (1 << w);
    if (b[w-1]) bi = bi - (1 << w);
    d = ai - bi;
    r.ovf = (d > (1 << (w - 1)) - 1) || (d < -(1 << (w - 1)));
    return r;
  endfunction

  task automatic wait_done8(input int budget);
    while (!if8.done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.Diff !== 8'h00 || if8.Borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b Diff=%h Borrow=%b, want 0 0 00 0", if8.busy, if8.done, if8.Diff, if8.Borrow);
    end
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.Diff !== 4'h0 || if4.Borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset4: busy=%b done=%b Diff=%h Borrow=%b, want 0 0 0 0", if4.busy, if4.done, if4.Diff, if4.Borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (if8.Ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: Ovf=%b want 0", if8.Ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", if8.busy, if8.done);
    end
  endtask

  task automatic test_arith;
    logic [7:0] ta[7] = '{8'd10, 8'd3, 8'h00, 8'h80, 8'h55, 8'hFF, 8'h7F};
    logic [7:0] tb[7] = '{8'd3, 8'd10, 8'hFF, 8'h01, 8'h55, 8'h00, 8'h80};
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if8.A = ta[i];
      if8.B = tb[i];
      if8.start = 1'b1;
      q8.push_back(model(8, ta[i], tb[i]));
      @(negedge clk);
      if8.start = 1'b0;
      if8.A = 8'($urandom);
      if8.B = 8'($urandom);
      lat = 1;
      checks++;
      if (if8.busy !== 1'b1) begin
        errors++;
        $display("FAIL arith_busy[%0d]: busy=%b want 1", i, if8.busy);
      end
      wait_done8(40);
      checks++;
      if (lat !== 10) begin
        errors++;
        $display("FAIL arith_latency[%0d]: got %0d want 10", i, lat);
      end
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL arith_queue[%0d]: scoreboard empty", i);
        continue;
      end
      e = q8.pop_front();
      last_diff8 = e.diff;
      checks++;
      if (if8.Diff !== e.diff || if8.Borrow !== e.borrow) begin
        errors++;
        $display("FAIL arith[%0d] %h-%h: Diff=%h Borrow=%b want %h %b", i, ta[i], tb[i], if8.Diff, if8.Borrow, e.diff, e.borrow);
      end
      checks++;
      if (if8.busy !== 1'b1) begin
        errors++;
        $display("FAIL arith_busy_done[%0d]: busy=%b want 1", i, if8.busy);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (if8.Ovf !== e.ovf) begin
        errors++;
        $display("FAIL arith_ovf[%0d]: Ovf=%b want %b", i, if8.Ovf, e.ovf);
      end
`endif
    end
  endtask

  task automatic test_busy_ignore;
    int dones = 0;
    @(negedge clk);
    if8.A = 8'd5;
    if8.B = 8'd2;
    if8.start = 1'b1;
    q8.push_back(model(8, 8'd5, 8'd2));
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if8.start = (c == 3);
      if (c == 3) begin
        if8.A = 8'd9;
        if8.B = 8'd9;
      end
      if (if8.done) begin
        dones++;
        if (q8.size() != 0) begin
          e = q8.pop_front();
          last_diff8 = e.diff;
          checks++;
          if (if8.Diff !== e.diff || if8.Borrow !== e.borrow) begin
            errors++;
            $display("FAIL ignore_result: Diff=%h Borrow=%b want %h %b", if8.Diff, if8.Borrow, e.diff, e.borrow);
          end
        end
      end else if (c <= 9) begin
        checks++;
        if (if8.busy !== 1'b1 || if8.Diff !== last_diff8) begin
          errors++;
          $display("FAIL ignore_hold[c%0d]: busy=%b Diff=%h want 1 %h", c, if8.busy, if8.Diff, last_diff8);
        end
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_midop;
    int dones = 0;
    @(negedge clk);
    if8.A = 8'h33;
    if8.B = 8'h11;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.Diff !== 8'h00 || if8.Borrow !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b done=%b Diff=%h Borrow=%b want 0 0 00 0", if8.busy, if8.done, if8.Diff, if8.Borrow);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (if8.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midop_no_done: got %0d done pulses want 0", dones);
    end
    if8.A = 8'h20;
    if8.B = 8'h30;
    if8.start = 1'b1;
    q8.push_back(model(8, 8'h20, 8'h30));
    @(negedge clk);
    if8.start = 1'b0;
    lat = 1;
    wait_done8(40);
    checks++;
    if (!if8.done || q8.size() == 0) begin
      errors++;
      $display("FAIL midop_fresh_timeout: done=%b queue=%0d", if8.done, q8.size());
    end else begin
      e = q8.pop_front();
      last_diff8 = e.diff;
      if (if8.Diff !== e.diff || if8.Borrow !== e.borrow) begin
        errors++;
        $display("FAIL midop_fresh: Diff=%h Borrow=%b want %h %b", if8.Diff, if8.Borrow, e.diff, e.borrow);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] oa[3] = '{8'h12, 8'h01, 8'hC8};
    logic [7:0] ob[3] = '{8'h34, 8'h01, 8'h64};
    @(negedge clk);
    if8.A = oa[0];
    if8.B = ob[0];
    if8.start = 1'b1;
    q8.push_back(model(8, oa[0], ob[0]));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin
        if8.A = oa[i+1];
        if8.B = ob[i+1];
        q8.push_back(model(8, oa[i+1], ob[i+1]));
      end else begin
        if8.start = 1'b0;
      end
      checks++;
      if (if8.busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy[%0d]: busy=%b want 1", i, if8.busy);
      end
      lat = 1;
      wait_done8(40);
      checks++;
      if (lat !== 10 || q8.size() == 0) begin
        errors++;
        $display("FAIL b2b_period[%0d]: latency %0d want 10, queue %0d", i, lat, q8.size());
      end else begin
        e = q8.pop_front();
        checks++;
        if (if8.Diff !== e.diff || if8.Borrow !== e.borrow) begin
          errors++;
          $display("FAIL b2b[%0d]: Diff=%h Borrow=%b want %h %b", i, if8.Diff, if8.Borrow, e.diff, e.borrow);
        end
      end
    end
  endtask

  task automatic test_sweep4;
    int l4;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if4.A = 4'(a);
        if4.B = 4'(b);
        if4.start = 1'b1;
        q4.push_back(model(4, 8'(a), 8'(b)));
        @(negedge clk);
        if4.start = 1'b0;
        l4 = 1;
        while (!if4.done && l4 < 20) begin
          @(negedge clk);
          l4++;
        end
        checks++;
        if (l4 !== 6 || q4.size() == 0) begin
          errors++;
          $display("FAIL sweep4_latency %0d-%0d: latency %0d want 6", a, b, l4);
          q4.delete();
          continue;
        end
        e = q4.pop_front();
        checks++;
        if (if4.Diff !== e.diff[3:0] || if4.Borrow !== e.borrow) begin
          errors++;
          $display("FAIL sweep4 %0d-%0d: Diff=%h Borrow=%b want %h %b", a, b, if4.Diff, if4.Borrow, e.diff[3:0], e.borrow);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (if4.Ovf !== e.ovf) begin
          errors++;
          $display("FAIL sweep4_ovf %0d-%0d: Ovf=%b want %b", a, b, if4.Ovf, e.ovf);
        end
`endif
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if8.start = 1'b0;
    if8.A = '0;
    if8.B = '0;
    if4.start = 1'b0;
    if4.A = '0;
    if4.B = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_arith;
    test_busy_ignore;
    test_reset_midop;
    test_back_to_back;
    test_sweep4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
